// File: rtl/mic_tdm_pkg.sv
// mic_tdm_pkg: shared types and constants for the mic_tdm_src serial audio source.
// lfsr_taps() feeds the optional LFSR sample generator (MIC_LFSR_EN).
package mic_tdm_pkg;

    localparam int MAX_CHAN = 8;

    typedef enum logic [1:0] {
        MODE_I2S = 2'd0,
        MODE_LJ  = 2'd1,
        MODE_TDM = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_e;

    // Galois right-shift masks for maximal-length LFSRs
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            24:      taps = 32'h00E1_0000;
            default: taps = 32'h8020_0003;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/mic_pin_sync.sv
// mic_pin_sync: 2-flop synchroniser for an asynchronous pad input,
// plus one-cycle rise/fall strobes taken from the synchronised level.
module mic_pin_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    // two metastability stages followed by one history stage for edges
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], pin_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/mic_tdm_src.sv
// mic_tdm_src: slave-mode I2S / left-justified / TDM serial audio source.
// Define MIC_LFSR_EN to replace the ramp generators with per-channel LFSRs.
module mic_tdm_src
    import mic_tdm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int CHAN_NUM   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] step_i,
    input  logic                  sck_i,
    input  logic                  ws_i,
    output logic                  sd_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  sync_err_o
);

    localparam int NCH     = (CHAN_NUM > MAX_CHAN) ? MAX_CHAN : CHAN_NUM;
    localparam int BIT_W   = $clog2(SLOT_WIDTH);
    localparam int GAP_MAX = 8 * SLOT_WIDTH + 1;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_TOP  = GAP_W'(GAP_MAX);
    localparam logic [GAP_W-1:0] THR_LR   = GAP_W'(SLOT_WIDTH + 1);
    localparam logic [GAP_W-1:0] THR_TDM  = GAP_W'(8 * SLOT_WIDTH);

    typedef logic [DATA_WIDTH-1:0] word_t;

    function automatic word_t gen_init(input int c);
`ifdef MIC_LFSR_EN
        return word_t'(c + 1);
`else
        return word_t'(c) << (DATA_WIDTH - 4);
`endif
    endfunction

`ifdef MIC_LFSR_EN
    function automatic word_t lfsr_next(input word_t cur);
        logic [31:0] taps;
        word_t       nxt;
        taps = lfsr_taps(DATA_WIDTH);
        nxt  = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ taps[DATA_WIDTH-1:0];
        end
        return nxt;
    endfunction

    logic unused_step;
    assign unused_step = ^step_i;
`endif

    function automatic mode_e map_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'd1:    r = MODE_LJ;
            2'd2:    r = MODE_TDM;
            default: r = MODE_I2S;
        endcase
        return r;
    endfunction

    logic sck_fall;
    logic unused_sck_lvl;
    logic unused_sck_rise;
    logic ws_s;
    logic unused_ws_rise;
    logic unused_ws_fall;

    mic_pin_sync u_sck_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .pin_i   (sck_i),
        .level_o (unused_sck_lvl),
        .rise_o  (unused_sck_rise),
        .fall_o  (sck_fall)
    );

    mic_pin_sync u_ws_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .pin_i   (ws_i),
        .level_o (ws_s),
        .rise_o  (unused_ws_rise),
        .fall_o  (unused_ws_fall)
    );

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic             en_q;
    logic             ws_prev_q, ws_prev_d;
    word_t            sr_q, sr_d;
    logic             sd_q, sd_d;
    logic [3:0]       slot_q, slot_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             err_q, err_d;
    logic [15:0]      fcnt_q, fcnt_d;
    word_t            gen_q [NCH];
    word_t            gen_d [NCH];

    logic             en_rise;
    logic             is_tdm;
    logic             is_i2s;
    logic             ws_chg;
    logic             frame_start;
    logic             active;
    logic             sync_evt;
    logic             load;
    logic [3:0]       ld_idx;
    word_t            sample;
    logic [GAP_W-1:0] thr;

    assign en_rise     = en_i & ~en_q;
    assign is_tdm      = (mode_q == MODE_TDM);
    assign is_i2s      = (mode_q == MODE_I2S);
    assign ws_chg      = ws_s ^ ws_prev_q;
    assign frame_start = is_tdm ? (ws_s & ~ws_prev_q)
                                : (~ws_s & ws_prev_q);
    assign thr         = is_tdm ? THR_TDM : THR_LR;
    assign active      = (state_q == RUN) ||
                         ((state_q == WAIT_SYNC) && frame_start);

    // next-state logic: enable gates everything, first frame start locks on
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (en_rise) state_d = WAIT_SYNC;
            WAIT_SYNC: if (sck_fall && frame_start) state_d = RUN;
            RUN:       state_d = RUN;
            default:   state_d = IDLE;
        endcase
        if (!en_i) begin
            state_d = IDLE;
        end
    end

    // per-sck-fall framing, slot tracking, sample load and serialisation
    always_comb begin
        mode_d    = mode_q;
        ws_prev_d = ws_prev_q;
        sr_d      = sr_q;
        sd_d      = sd_q;
        slot_d    = slot_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        err_d     = err_q;
        fcnt_d    = fcnt_q;
        gen_d     = gen_q;
        sync_evt  = 1'b0;
        load      = 1'b0;
        ld_idx    = 4'd0;
        sample    = '0;

        if (en_rise) begin
            mode_d = map_mode(mode_i);
        end
        if (sck_fall) begin
            ws_prev_d = ws_s;
        end

        if (state_d == IDLE) begin
            sr_d   = '0;
            sd_d   = 1'b0;
            slot_d = 4'd0;
            bit_d  = '0;
            gap_d  = '0;
            err_d  = 1'b0;
            fcnt_d = 16'd0;
            for (int c = 0; c < NCH; c++) begin
                gen_d[c] = gen_init(c);
            end
        end else if (sck_fall) begin
            sync_evt = is_tdm ? frame_start : ws_chg;
            if (sync_evt) begin
                gap_d = '0;
            end else begin
                if (gap_q != GAP_TOP) begin
                    gap_d = gap_q + 1'b1;
                end
                if (gap_d > thr) begin
                    err_d = 1'b1;
                end
            end

            if (active) begin
                if (frame_start) begin
                    fcnt_d = fcnt_q + 16'd1;
                end

                if (is_tdm) begin
                    if (frame_start) begin
                        slot_d = 4'd0;
                        bit_d  = '0;
                        load   = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        load  = 1'b1;
                        if (slot_q != 4'hF) begin
                            slot_d = slot_q + 4'd1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                    ld_idx = slot_d;
                end else begin
                    load   = ws_chg;
                    ld_idx = {3'b000, ws_s};
                end

                // indices beyond the generated channels read as silence
                for (int c = 0; c < NCH; c++) begin
                    if (ld_idx == 4'(c)) begin
                        sample = gen_q[c];
                        if (load) begin
`ifdef MIC_LFSR_EN
                            gen_d[c] = lfsr_next(gen_q[c]);
`else
                            gen_d[c] = gen_q[c] + step_i;
`endif
                        end
                    end
                end

                // I2S keeps shifting the old word for one more bit
                if (is_i2s) begin
                    sd_d = sr_q[DATA_WIDTH-1];
                    sr_d = load ? sample : (sr_q << 1);
                end else begin
                    sd_d = load ? sample[DATA_WIDTH-1]
                                : sr_q[DATA_WIDTH-1];
                    sr_d = load ? (sample << 1) : (sr_q << 1);
                end
            end else begin
                sd_d = 1'b0;
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            mode_q    <= MODE_I2S;
            en_q      <= 1'b0;
            ws_prev_q <= 1'b0;
            sr_q      <= '0;
            sd_q      <= 1'b0;
            slot_q    <= 4'd0;
            bit_q     <= '0;
            gap_q     <= '0;
            err_q     <= 1'b0;
            fcnt_q    <= 16'd0;
            for (int c = 0; c < NCH; c++) begin
                gen_q[c] <= gen_init(c);
            end
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            en_q      <= en_i;
            ws_prev_q <= ws_prev_d;
            sr_q      <= sr_d;
            sd_q      <= sd_d;
            slot_q    <= slot_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            err_q     <= err_d;
            fcnt_q    <= fcnt_d;
            gen_q     <= gen_d;
        end
    end

    assign sd_o        = sd_q;
    assign frame_cnt_o = fcnt_q;
    assign sync_err_o  = err_q;

endmodule
